// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//
// Purpose:
//   Consumes PS/2 Set-2 scan-code bytes from the frame deserializer. It parses
//   make/break sequences with the E0 (extended) and F0 (break) prefixes and
//   keeps held/released state for two players' five game keys each.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high, overrides every input
//   code       in   8  received scan-code byte, qualified by code_valid
//   code_valid in   1  single-cycle strobe, one per received byte
//   p1keys     out  5  player-1 held keys {fire,right,left,down,up}
//   p2keys     out  5  player-2 held keys {fire,right,left,down,up}
//   debugLEDs  out  8  last fully resolved (non-prefix) code byte
//   key_event  out  1  one-cycle pulse when a mapped key bit toggles
//
// Parameters:
//   TIMEOUT_CYCLES  cycles a prefix state waits for the next byte before
//                   falling back to idle
//   CNT_W           width of the timeout counter
//
// Configuration macro:
//   KEYPAD_ALIAS_EN  when defined, non-extended 75/72/6B/74 (numeric keypad
//                    8/2/4/6 with NumLock on) also drive p2 up/down/left/right.
//
// Timing: a byte strobed in one cycle is reflected on all outputs one clock
// edge later. All outputs are registered.

module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic [4:0] p1keys,
  output logic [4:0] p2keys,
  output logic [7:0] debugLEDs,
  output logic       key_event
);

  // Bit positions inside a player's key vector.
  localparam int unsigned KeyUp    = 0;
  localparam int unsigned KeyDown  = 1;
  localparam int unsigned KeyLeft  = 2;
  localparam int unsigned KeyRight = 3;
  localparam int unsigned KeyFire  = 4;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  // The encoding is {break, extended}, so each state records the prefixes
  // seen so far in the current sequence.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StExt    = 2'b01,
    StBrk    = 2'b10,
    StExtBrk = 2'b11
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_p1;
  logic [4:0]       r_p2;
  logic [7:0]       r_dbg;
  logic             r_key_event;

  logic       w_is_e0;
  logic       w_is_f0;
  logic       w_is_ignored;
  logic       w_is_error;
  logic       w_ext;
  logic       w_brk;
  logic [4:0] w_p1_mask;
  logic [4:0] w_p2_mask;
  logic [4:0] w_p1_next;
  logic [4:0] w_p2_next;

  // Byte classification.
  always_comb begin
    w_is_e0      = (code == 8'hE0);
    w_is_f0      = (code == 8'hF0);
    // Ack, BAT pass, echo and the pause prefix carry no key information.
    w_is_ignored = (code == 8'hFA) || (code == 8'hAA) ||
                   (code == 8'hEE) || (code == 8'hE1);
    // Keyboard buffer overrun: held-key state can no longer be trusted.
    w_is_error   = (code == 8'h00) || (code == 8'hFF);
    w_ext        = (r_state == StExt) || (r_state == StExtBrk);
    w_brk        = (r_state == StBrk) || (r_state == StExtBrk);
  end

  // Key map. A mapped code selects one bit in exactly one player's vector.
  // A code with the wrong extension leaves both masks at zero.
  always_comb begin
    w_p1_mask = '0;
    w_p2_mask = '0;
    if (!w_ext) begin
      unique case (code)
        8'h1D:   w_p1_mask[KeyUp]    = 1'b1;
        8'h1B:   w_p1_mask[KeyDown]  = 1'b1;
        8'h1C:   w_p1_mask[KeyLeft]  = 1'b1;
        8'h23:   w_p1_mask[KeyRight] = 1'b1;
        8'h29:   w_p1_mask[KeyFire]  = 1'b1;
        8'h5A:   w_p2_mask[KeyFire]  = 1'b1;
`ifdef KEYPAD_ALIAS_EN
        8'h75:   w_p2_mask[KeyUp]    = 1'b1;
        8'h72:   w_p2_mask[KeyDown]  = 1'b1;
        8'h6B:   w_p2_mask[KeyLeft]  = 1'b1;
        8'h74:   w_p2_mask[KeyRight] = 1'b1;
`endif
        default: ;
      endcase
    end else begin
      unique case (code)
        8'h75:   w_p2_mask[KeyUp]    = 1'b1;
        8'h72:   w_p2_mask[KeyDown]  = 1'b1;
        8'h6B:   w_p2_mask[KeyLeft]  = 1'b1;
        8'h74:   w_p2_mask[KeyRight] = 1'b1;
        8'h5A:   w_p2_mask[KeyFire]  = 1'b1;
        default: ;
      endcase
    end
  end

  // Resolve: make sets the mapped bit and break clears it. Setting or
  // clearing a bit that is already in that state is a no-op. This is what
  // keeps typematic repeats from producing key_event pulses.
  always_comb begin
    w_p1_next = w_brk ? (r_p1 & ~w_p1_mask) : (r_p1 | w_p1_mask);
    w_p2_next = w_brk ? (r_p2 & ~w_p2_mask) : (r_p2 | w_p2_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_dbg       <= '0;
      r_key_event <= 1'b0;
    end else begin
      r_key_event <= 1'b0;
      if (code_valid) begin
        // A byte always restarts the timeout. When it lands on the expiry
        // cycle it is still processed in the current prefix state.
        r_cnt <= '0;
        if (w_is_e0 || w_is_f0) begin
          unique case (r_state)
            StIdle:   r_state <= w_is_e0 ? StExt : StBrk;
            StExt:    r_state <= w_is_f0 ? StExtBrk : StExt;
            StBrk:    r_state <= w_is_e0 ? StExtBrk : StBrk;
            StExtBrk: r_state <= StExtBrk;
            default:  r_state <= StIdle;
          endcase
        end else if (w_is_ignored) begin
          r_state <= StIdle;
        end else if (w_is_error) begin
          r_state     <= StIdle;
          r_p1        <= '0;
          r_p2        <= '0;
          r_dbg       <= code;
          r_key_event <= |{r_p1, r_p2};
        end else begin
          r_state     <= StIdle;
          r_p1        <= w_p1_next;
          r_p2        <= w_p2_next;
          r_dbg       <= code;
          r_key_event <= (w_p1_next != r_p1) || (w_p2_next != r_p2);
        end
      end else if (r_state == StIdle) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        // The keyboard abandoned the sequence. Drop the prefix without
        // changing any key state.
        r_state <= StIdle;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign p1keys    = r_p1;
  assign p2keys    = r_p2;
  assign debugLEDs = r_dbg;
  assign key_event = r_key_event;

endmodule
